// File: rtl/cpu_mem_pkg.sv
// Shared encodings and defaults for the processor data-memory port.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0]  DEF_STACK_TOP   = 8'hFF;
    localparam int unsigned DEF_STACK_DEPTH = 16;

    function automatic logic is_read(input op_t op);
        return (op == OP_LOAD) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response bus of the data-memory controller.
interface mem_access_ctrl_if;
    import cpu_mem_pkg::*;

    logic       req_valid;
    logic       req_ready;
    op_t        req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/stack_ptr_ctr.sv
// Hardware stack pointer and occupancy; stack grows downward from STACK_TOP.
module stack_ptr_ctr #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter logic [7:0]  STACK_TOP   = 8'hFF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] sp,
    output logic [7:0] depth,
    output logic       full,
    output logic       empty
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp    <= STACK_TOP;
            depth <= '0;
        end else if (push) begin
            sp    <= sp - 8'd1;
            depth <= depth + 8'd1;
        end else if (pop) begin
            sp    <= sp + 8'd1;
            depth <= depth - 8'd1;
        end
    end

    assign full  = (depth == 8'(STACK_DEPTH));
    assign empty = (depth == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: sequences Rm/Wm strobes for load/store/push/pop requests.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
    parameter logic [7:0]  STACK_TOP   = DEF_STACK_TOP
) (
    input  logic             clock,
    input  logic             reset_n,
    mem_access_ctrl_if.slave bus,
    output logic             mem_rm,
    output logic             mem_wm,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic [7:0]       sp,
    output logic [7:0]       depth
);

    state_t     state, state_nxt;
    op_t        op_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic       accept, reject;
    logic       stk_push, stk_pop, stk_full, stk_empty;

    stack_ptr_ctr #(
        .STACK_DEPTH (STACK_DEPTH),
        .STACK_TOP   (STACK_TOP)
    ) u_stack (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (stk_push),
        .pop     (stk_pop),
        .sp      (sp),
        .depth   (depth),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    assign accept = (state == ST_IDLE) && bus.req_valid;
    assign reject = accept && (((bus.req_op == OP_PUSH) && stk_full) ||
                               ((bus.req_op == OP_POP)  && stk_empty));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        mem_rm        = 1'b0;
        mem_wm        = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) state_nxt = reject ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_rm    = is_read(op_q);
                mem_wm    = !is_read(op_q);
                stk_push  = (op_q == OP_PUSH);
                stk_pop   = (op_q == OP_POP);
                state_nxt = is_read(op_q) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: state_nxt = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address/data are resolved at accept time straight into the output
    // registers, so they are valid throughout ISSUE and hold afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_LOAD;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.req_op;
                err_q <= reject;
                if (!reject) begin
                    case (bus.req_op)
                        OP_PUSH: mem_addr <= sp;
                        OP_POP:  mem_addr <= sp + 8'd1;
                        default: mem_addr <= bus.req_addr;
                    endcase
                    if (!is_read(bus.req_op)) mem_wdata <= bus.req_wdata;
                end
            end
            if (state == ST_WAIT) rdata_q <= mem_rdata;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = (state == ST_RESP) && err_q;

endmodule
